// File: rtl/rs_bm_ctrl.sv
// ---------------------------------------------------------------------------
// rs_bm_ctrl
//
// Sequencer for the iterative Berlekamp-Massey stage of the Reed-Solomon
// decoder. It accepts a syndrome block through a valid/ready handshake and
// loads the shared iteration datapath. It then steps the datapath through
// ROOTS_NUM iterations, one per cycle. It owns the LFSR length L and the
// length-change decision. It hands the final error-locator length and the
// decode-failure flag to the Chien/Forney stage through a valid/ready
// handshake.
//
// Ports
//   aclk, aresetn   clock; asynchronous active-low reset
//   flush           synchronous abort back to IDLE (no result, no count)
//   syn_vld/syn_rdy syndrome block handshake; syn_zero sampled with syn_vld
//   dp_init         one-cycle datapath load strobe (Lambda=1, B=1)
//   dp_iter_en      datapath executes iteration dp_iter_idx (1..ROOTS_NUM)
//   dp_delta_nz     discrepancy non-zero, combinational from datapath
//   dp_len_upd      combinational length-change decision for the datapath
//   res_vld/res_rdy result handshake carrying err_len and decode_error
//   busy            controller not idle
//   fail_cnt        saturating count of delivered results flagged as failed
// ---------------------------------------------------------------------------
module rs_bm_ctrl #(
    parameter int ROOTS_NUM = 16,
    parameter int T_VAL     = ROOTS_NUM / 2,
    parameter int LEN_WIDTH = $clog2(ROOTS_NUM + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 flush,
    input  logic                 syn_vld,
    input  logic                 syn_zero,
    output logic                 syn_rdy,
    output logic                 dp_init,
    output logic                 dp_iter_en,
    output logic [LEN_WIDTH-1:0] dp_iter_idx,
    input  logic                 dp_delta_nz,
    output logic                 dp_len_upd,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [LEN_WIDTH-1:0] err_len,
    output logic                 decode_error,
    output logic                 busy,
    output logic [15:0]          fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] R_LAST   = LEN_WIDTH'(ROOTS_NUM);
    localparam logic [LEN_WIDTH-1:0] T_LIMIT  = LEN_WIDTH'(T_VAL);
    localparam logic [15:0]          CNT_MAX  = 16'hFFFF;

    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   len_q;        // LFSR length L
    logic [LEN_WIDTH-1:0]   r_q;          // iteration index, 0 outside ITER
    logic                   syn_zero_q;
    logic                   syn_rdy_q;
    logic                   dp_init_q;
    logic                   dp_iter_en_q;
    logic                   res_vld_q;
    logic [LEN_WIDTH-1:0]   err_len_q;
    logic                   decode_error_q;
    logic                   busy_q;
    logic [15:0]            fail_cnt_q;

    logic [LEN_WIDTH:0]     two_len_s;
    logic [LEN_WIDTH:0]     r_minus1_s;
    logic                   len_upd_s;
    logic [LEN_WIDTH-1:0]   len_d;

    // Length-change decision and next L; 2L <= r-1 is evaluated one bit wider
    // so that 2L cannot wrap for L up to ROOTS_NUM.
    always_comb begin
        two_len_s  = {len_q, 1'b0};
        r_minus1_s = {1'b0, r_q} - {{LEN_WIDTH{1'b0}}, 1'b1};
        len_upd_s  = 1'b0;
        len_d      = len_q;
        if (state_q == ST_ITER) begin
            len_upd_s = dp_delta_nz && (two_len_s <= r_minus1_s);
            if (len_upd_s) begin
                len_d = r_q - len_q;
            end else begin
                len_d = len_q;
            end
        end else begin
            len_upd_s = 1'b0;
            len_d     = len_q;
        end
    end

    // Controller FSM: state, L, r and all registered handshake/strobe outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            len_q          <= LEN_ZERO;
            r_q            <= LEN_ZERO;
            syn_zero_q     <= 1'b0;
            syn_rdy_q      <= 1'b1;
            dp_init_q      <= 1'b0;
            dp_iter_en_q   <= 1'b0;
            res_vld_q      <= 1'b0;
            err_len_q      <= LEN_ZERO;
            decode_error_q <= 1'b0;
            busy_q         <= 1'b0;
            fail_cnt_q     <= 16'h0000;
        end else if (flush) begin
            // Abort: drop any pending result without a handshake or count.
            state_q      <= ST_IDLE;
            len_q        <= LEN_ZERO;
            r_q          <= LEN_ZERO;
            syn_rdy_q    <= 1'b1;
            dp_init_q    <= 1'b0;
            dp_iter_en_q <= 1'b0;
            res_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (syn_vld) begin
                        state_q    <= ST_INIT;
                        syn_zero_q <= syn_zero;
                        syn_rdy_q  <= 1'b0;
                        dp_init_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        syn_rdy_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_INIT: begin
                    dp_init_q <= 1'b0;
                    len_q     <= LEN_ZERO;
                    if (syn_zero_q) begin
                        // Nothing to correct: skip the iterations entirely.
                        state_q        <= ST_DONE;
                        r_q            <= LEN_ZERO;
                        res_vld_q      <= 1'b1;
                        err_len_q      <= LEN_ZERO;
                        decode_error_q <= 1'b0;
                    end else begin
                        state_q      <= ST_ITER;
                        r_q          <= LEN_ONE;
                        dp_iter_en_q <= 1'b1;
                    end
                end
                ST_ITER: begin
                    len_q <= len_d;
                    if (r_q == R_LAST) begin
                        state_q        <= ST_DONE;
                        r_q            <= LEN_ZERO;
                        dp_iter_en_q   <= 1'b0;
                        res_vld_q      <= 1'b1;
                        err_len_q      <= len_d;
                        decode_error_q <= (len_d > T_LIMIT);
                    end else begin
                        r_q <= r_q + LEN_ONE;
                    end
                end
                ST_DONE: begin
                    if (res_rdy) begin
                        state_q   <= ST_IDLE;
                        res_vld_q <= 1'b0;
                        syn_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                        if (decode_error_q && (fail_cnt_q != CNT_MAX)) begin
                            fail_cnt_q <= fail_cnt_q + 16'd1;
                        end else begin
                            fail_cnt_q <= fail_cnt_q;
                        end
                    end else begin
                        res_vld_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    len_q        <= LEN_ZERO;
                    r_q          <= LEN_ZERO;
                    syn_rdy_q    <= 1'b1;
                    dp_init_q    <= 1'b0;
                    dp_iter_en_q <= 1'b0;
                    res_vld_q    <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign syn_rdy      = syn_rdy_q;
    assign dp_init      = dp_init_q;
    assign dp_iter_en   = dp_iter_en_q;
    assign dp_iter_idx  = r_q;
    assign dp_len_upd   = len_upd_s;
    assign res_vld      = res_vld_q;
    assign err_len      = err_len_q;
    assign decode_error = decode_error_q;
    assign busy         = busy_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_rs_bm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rs_bm_ctrl
//
// Scoreboard bench for rs_bm_ctrl with ROOTS_NUM=4, T_VAL=2. The stimulus
// process pushes hand-computed length-update decisions and results into
// queues; a negedge monitor pops and compares whenever the DUT iterates or
// presents a result, and also checks handshake-relative timing.
// ---------------------------------------------------------------------------
module tb_rs_bm_ctrl;

    localparam int RN = 4;
    localparam int TV = 2;
    localparam int LW = 3;

    logic          aclk;
    logic          aresetn;
    logic          flush;
    logic          syn_vld;
    logic          syn_zero;
    logic          syn_rdy;
    logic          dp_init;
    logic          dp_iter_en;
    logic [LW-1:0] dp_iter_idx;
    logic          dp_delta_nz;
    logic          dp_len_upd;
    logic          res_vld;
    logic          res_rdy;
    logic [LW-1:0] err_len;
    logic          decode_error;
    logic          busy;
    logic [15:0]   fail_cnt;

    // Discrepancy pattern for the current block, indexed by iteration r.
    logic [7:0]    dnz;

    rs_bm_ctrl #(.ROOTS_NUM(RN), .T_VAL(TV), .LEN_WIDTH(LW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .flush        (flush),
        .syn_vld      (syn_vld),
        .syn_zero     (syn_zero),
        .syn_rdy      (syn_rdy),
        .dp_init      (dp_init),
        .dp_iter_en   (dp_iter_en),
        .dp_iter_idx  (dp_iter_idx),
        .dp_delta_nz  (dp_delta_nz),
        .dp_len_upd   (dp_len_upd),
        .res_vld      (res_vld),
        .res_rdy      (res_rdy),
        .err_len      (err_len),
        .decode_error (decode_error),
        .busy         (busy),
        .fail_cnt     (fail_cnt)
    );

    assign dp_delta_nz = dp_iter_en & dnz[dp_iter_idx];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int len;
        int dec;
        int lat;
    } res_t;

    res_t exp_res_q[$];
    int   exp_upd_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int hs_cyc  = 0;
    bit vld_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: timing relative to the input handshake and scoreboard pops.
    always @(negedge aclk) begin
        res_t r;
        int   e;
        cyc++;
        if (!aresetn) begin
            vld_prev = 1'b0;
        end else begin
            if (syn_vld && syn_rdy) hs_cyc = cyc;
            if (dp_init) chk("init_cycle", cyc - hs_cyc, 1);
            if (dp_iter_en) begin
                chk("iter_idx", int'(dp_iter_idx), cyc - hs_cyc - 1);
                if (exp_upd_q.size() == 0) begin
                    chk("iter_unexpected", exp_upd_q.size(), 1);
                end else begin
                    e = exp_upd_q.pop_front();
                    chk("len_upd", int'(dp_len_upd), e);
                end
            end else if (dp_len_upd) begin
                chk("len_upd_outside_iter", int'(dp_len_upd), 0);
            end
            if (res_vld && !vld_prev) begin
                if (exp_res_q.size() == 0) begin
                    chk("res_unexpected", exp_res_q.size(), 1);
                end else begin
                    chk("res_latency", cyc - hs_cyc, exp_res_q[0].lat);
                end
            end
            if (res_vld && res_rdy && exp_res_q.size() != 0) begin
                r = exp_res_q.pop_front();
                chk("err_len", int'(err_len), r.len);
                chk("decode_error", int'(decode_error), r.dec);
            end
            vld_prev = res_vld;
        end
    end

    task automatic send(input bit zero, input logic [4:1] dseq, input logic [4:1] upd,
                        input int len, input int dec);
        res_t r;
        int   n = 0;
        while (!syn_rdy && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("syn_rdy_timeout", int'(syn_rdy), 1);
        if (!zero) begin
            for (int i = 1; i <= RN; i++) exp_upd_q.push_back(int'(upd[i]));
        end
        r.len = len;
        r.dec = dec;
        r.lat = zero ? 2 : RN + 2;
        exp_res_q.push_back(r);
        dnz      = {3'b000, dseq, 1'b0};
        syn_vld  = 1'b1;
        syn_zero = zero;
        @(posedge aclk); #1;
        syn_vld  = 1'b0;
        syn_zero = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_iter(input int r);
        int n = 0;
        while (!(dp_iter_en && int'(dp_iter_idx) == r) && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("iter_wait_timeout", int'(dp_iter_idx), r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn  = 1'b0;
        flush    = 1'b0;
        syn_vld  = 1'b0;
        syn_zero = 1'b0;
        res_rdy  = 1'b1;
        dnz      = 8'h00;
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Reset state
        chk("rst_syn_rdy", int'(syn_rdy), 1);
        chk("rst_res_vld", int'(res_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_err_len", int'(err_len), 0);
        chk("rst_dec_err", int'(decode_error), 0);
        chk("rst_iter_en", int'(dp_iter_en), 0);
        chk("rst_iter_idx", int'(dp_iter_idx), 0);
        chk("rst_init", int'(dp_init), 0);

        // All-zero syndromes: no iterations, L=0
        send(1'b1, 4'b0000, 4'b0000, 0, 0);
        wait_idle();
        chk("zero_fail_cnt", int'(fail_cnt), 0);

        // delta 1,0,0,0 -> upd 1,0,0,0, L=1
        send(1'b0, 4'b0001, 4'b0001, 1, 0);
        wait_idle();

        // delta 1,1,1,1 -> upd 1,0,1,0, L=2
        send(1'b0, 4'b1111, 4'b0101, 2, 0);
        wait_idle();

        // delta 1,0,0,1 -> upd 1,0,0,1, L=3 > T -> decode error
        send(1'b0, 4'b1001, 4'b1001, 3, 1);
        wait_idle();
        chk("fail_cnt_after_err", int'(fail_cnt), 1);

        // Backpressure in DONE with syn_vld pulses ignored
        res_rdy = 1'b0;
        send(1'b0, 4'b1001, 4'b1001, 3, 1);
        begin
            int n = 0;
            while (!res_vld && n < 50) begin
                @(posedge aclk); #1;
                n++;
            end
        end
        chk("hold_vld_timeout", int'(res_vld), 1);
        for (int i = 0; i < 5; i++) begin
            syn_vld = i[0];
            @(posedge aclk); #1;
            chk("hold_res_vld", int'(res_vld), 1);
            chk("hold_err_len", int'(err_len), 3);
            chk("hold_dec_err", int'(decode_error), 1);
            chk("hold_syn_rdy", int'(syn_rdy), 0);
        end
        syn_vld = 1'b0;
        res_rdy = 1'b1;
        @(posedge aclk); #1;
        chk("release_syn_rdy", int'(syn_rdy), 1);
        chk("release_res_vld", int'(res_vld), 0);
        chk("fail_cnt_after_hold", int'(fail_cnt), 2);

        // Flush during ITER at r=2
        send(1'b0, 4'b1111, 4'b0101, 2, 0);
        wait_iter(2);
        flush = 1'b1;
        syn_vld = 1'b1;
        @(posedge aclk); #1;
        flush = 1'b0;
        syn_vld = 1'b0;
        chk("flush_res_vld", int'(res_vld), 0);
        chk("flush_iter_en", int'(dp_iter_en), 0);
        chk("flush_busy", int'(busy), 0);
        chk("flush_syn_rdy", int'(syn_rdy), 1);
        chk("flush_fail_cnt", int'(fail_cnt), 2);
        exp_upd_q.delete();
        exp_res_q.delete();
        send(1'b0, 4'b0001, 4'b0001, 1, 0);
        wait_idle();
        chk("post_flush_fail_cnt", int'(fail_cnt), 2);

        // Asynchronous reset during ITER at r=3
        send(1'b0, 4'b1001, 4'b1001, 3, 1);
        wait_iter(3);
        #2 aresetn = 1'b0;
        #1;
        chk("areset_res_vld", int'(res_vld), 0);
        chk("areset_iter_en", int'(dp_iter_en), 0);
        chk("areset_iter_idx", int'(dp_iter_idx), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_fail_cnt", int'(fail_cnt), 0);
        exp_upd_q.delete();
        exp_res_q.delete();
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_syn_rdy", int'(syn_rdy), 1);
        send(1'b0, 4'b1111, 4'b0101, 2, 0);
        wait_idle();
        chk("post_rst_fail_cnt", int'(fail_cnt), 0);

        repeat (2) @(posedge aclk); #1;
        chk("res_queue_empty", exp_res_q.size(), 0);
        chk("upd_queue_empty", exp_upd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
